// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator front-end: ALU op codes, sequencer states,
// operand width and debounce length.
package calc_pkg;

  localparam int CALC_W      = 7;
  localparam int CALC_DB_CNT = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'd0;
  localparam op_t OP_SUB = 2'd1;
  localparam op_t OP_MUL = 2'd2;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_SHOW
  } state_t;

endpackage

// File: rtl/calc_btn_debounce.sv
// Button conditioner for one active-low push button: 2-FF synchronizer, stability counter
// and a one-cycle pulse when the debounced level returns high (button released).
module calc_btn_debounce
  import calc_pkg::*;
#(
  parameter int DB_CNT = CALC_DB_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic rel
);

  localparam logic [15:0] CNT_LAST = 16'(DB_CNT - 1);

  logic        sync_q1;
  logic        sync_q2;
  logic        level;
  logic [15:0] cnt;

  // Idle levels are "released" so leaving reset never looks like a release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      rel     <= 1'b0;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
      rel     <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_q2;
        rel   <= sync_q2;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator front-end: debounces the four buttons, sequences one ALU start/done round-trip
// per operation and holds the result for the display. Optional CALC_AUTO_REFRESH_EN relaunches on operand change.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int W      = CALC_W,
  parameter int DB_CNT = CALC_DB_CNT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           b_lig,
  input  logic           b_soma,
  input  logic           b_sub,
  input  logic           b_multi,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [1:0]     alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_start,
  input  logic           alu_done,
  input  logic [2*W-1:0] alu_y,
  input  logic           alu_neg,
  output logic [2*W-1:0] Y,
  output logic           sinal,
  output logic           EN,
  output logic           busy
);

  logic   ev_lig, ev_soma, ev_sub, ev_multi;
  logic   op_ev;
  op_t    op_sel;
  op_t    op_nxt;
  state_t state, state_nxt;
  logic   load_ops, clr_res, cap_res;

  calc_btn_debounce #(.DB_CNT(DB_CNT)) u_db_lig   (.clk(clk), .rst_n(rst_n), .btn_n(b_lig),   .rel(ev_lig));
  calc_btn_debounce #(.DB_CNT(DB_CNT)) u_db_soma  (.clk(clk), .rst_n(rst_n), .btn_n(b_soma),  .rel(ev_soma));
  calc_btn_debounce #(.DB_CNT(DB_CNT)) u_db_sub   (.clk(clk), .rst_n(rst_n), .btn_n(b_sub),   .rel(ev_sub));
  calc_btn_debounce #(.DB_CNT(DB_CNT)) u_db_multi (.clk(clk), .rst_n(rst_n), .btn_n(b_multi), .rel(ev_multi));

  // Coincident op releases resolve as add > sub > multiply.
  assign op_ev  = ev_soma | ev_sub | ev_multi;
  assign op_sel = ev_soma ? OP_ADD : (ev_sub ? OP_SUB : OP_MUL);

`ifdef CALC_AUTO_REFRESH_EN
  logic opnd_diff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) opnd_diff_q <= 1'b0;
    else        opnd_diff_q <= (A != alu_a) || (B != alu_b);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_OFF;
    else        state <= state_nxt;
  end

  // Power (lig) is checked first in every state, so it overrides ops and alu_done alike.
  always_comb begin
    state_nxt = state;
    load_ops  = 1'b0;
    op_nxt    = alu_op;
    clr_res   = 1'b0;
    cap_res   = 1'b0;
    case (state)
      ST_OFF: begin
        if (ev_lig) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (ev_lig) begin
          state_nxt = ST_OFF;
          clr_res   = 1'b1;
        end else if (op_ev) begin
          state_nxt = ST_LAUNCH;
          load_ops  = 1'b1;
          op_nxt    = op_sel;
        end
      end
      ST_LAUNCH: begin
        if (ev_lig) begin
          state_nxt = ST_OFF;
          clr_res   = 1'b1;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ev_lig) begin
          state_nxt = ST_OFF;
          clr_res   = 1'b1;
        end else if (alu_done) begin
          state_nxt = ST_SHOW;
          cap_res   = 1'b1;
        end
      end
      ST_SHOW: begin
        if (ev_lig) begin
          state_nxt = ST_OFF;
          clr_res   = 1'b1;
        end else if (op_ev) begin
          state_nxt = ST_LAUNCH;
          load_ops  = 1'b1;
          op_nxt    = op_sel;
        end
`ifdef CALC_AUTO_REFRESH_EN
        else if (opnd_diff_q) begin
          state_nxt = ST_LAUNCH;
          load_ops  = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = ST_OFF;
        clr_res   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= OP_ADD;
      alu_a  <= '0;
      alu_b  <= '0;
      Y      <= '0;
      sinal  <= 1'b0;
    end else begin
      if (load_ops) begin
        alu_op <= op_nxt;
        alu_a  <= A;
        alu_b  <= B;
      end
      if (clr_res) begin
        Y     <= '0;
        sinal <= 1'b0;
      end else if (cap_res) begin
        Y     <= alu_y;
        sinal <= alu_neg;
      end
    end
  end

  assign alu_start = (state == ST_LAUNCH);
  assign busy      = (state == ST_LAUNCH) || (state == ST_WAIT);
  assign EN        = (state != ST_OFF);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: directed scenarios, then random button/operand
// traffic checked against a transaction-level calculator model with a behavioural ALU responder.
module tb_calc_op_sequencer;
  import calc_pkg::*;

  localparam int W  = 7;
  localparam int YW = 2 * W;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    btn;
  logic [W-1:0]  A, B;
  logic [1:0]    alu_op;
  logic [W-1:0]  alu_a, alu_b;
  logic          alu_start, alu_done, alu_neg;
  logic [YW-1:0] alu_y, Y;
  logic          sinal, EN, busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int alu_lat   = 3;
  int lat_cnt   = 0;

  always #5 clk = ~clk;

  calc_op_sequencer #(.W(W), .DB_CNT(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .b_lig(btn[0]), .b_soma(btn[1]), .b_sub(btn[2]), .b_multi(btn[3]),
    .A(A), .B(B),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_done(alu_done), .alu_y(alu_y), .alu_neg(alu_neg),
    .Y(Y), .sinal(sinal), .EN(EN), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic void alu_ref(input logic [1:0] op, input int a, input int b,
                                  output logic [YW-1:0] y, output logic neg);
    neg = 1'b0;
    case (op)
      OP_ADD:  y = YW'(a + b);
      OP_SUB:  begin
        if (a < b) begin
          y   = YW'(b - a);
          neg = 1'b1;
        end else begin
          y = YW'(a - b);
        end
      end
      default: y = YW'(a * b);
    endcase
  endfunction

  // Behavioural ALU: answers alu_lat cycles after each observed start pulse.
  initial begin
    logic [YW-1:0] ry;
    logic          rn;
    alu_done = 1'b0;
    alu_y    = '0;
    alu_neg  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          alu_ref(alu_op, int'(alu_a), int'(alu_b), ry, rn);
          alu_y    = ry;
          alu_neg  = rn;
          alu_done = 1'b1;
        end
      end
      if (alu_start) begin
        start_cnt++;
        lat_cnt = alu_lat;
      end
    end
  end

  task automatic do_op(input logic [3:0] mask, input int a, input int b,
                       input logic [1:0] eop, input int ey, input logic eneg);
    int base;
    int n;
    A = W'(a);
    B = W'(b);
    tick(20);
    base = start_cnt;
    btn  = btn & ~mask;
    tick(10);
    btn = btn | mask;
    n = 0;
    while (!alu_start && n < 20) begin
      tick();
      n++;
    end
    check_eq("launch_lat", 32'(n), 32'd7);
    check_eq("alu_op", 32'(alu_op), 32'(eop));
    check_eq("alu_a", 32'(alu_a), 32'(a));
    check_eq("alu_b", 32'(alu_b), 32'(b));
    check_eq("busy_launch", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check_eq("busy_done", 32'(busy), 32'd0);
    check_eq("Y", 32'(Y), 32'(ey));
    check_eq("sinal", 32'(sinal), 32'(eneg));
    check_eq("EN_show", 32'(EN), 32'd1);
    check_eq("starts", 32'(start_cnt - base), 32'd1);
  endtask

  initial begin
    int            n;
    int            base;
    logic          exp_on, exp_shown, exp_neg;
    logic [1:0]    exp_op;
    int            exp_a, exp_b, exp_starts;
    logic [YW-1:0] exp_y;

    rst_n = 1'b0;
    btn   = 4'hF;
    A     = '0;
    B     = '0;

    // Reset values
    tick(3);
    check_eq("rst_EN", 32'(EN), 32'd0);
    check_eq("rst_Y", 32'(Y), 32'd0);
    check_eq("rst_sinal", 32'(sinal), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(alu_start), 32'd0);
    check_eq("rst_op", 32'(alu_op), 32'd0);
    check_eq("rst_a", 32'(alu_a), 32'd0);
    check_eq("rst_b", 32'(alu_b), 32'd0);
    rst_n = 1'b1;
    tick(50);
    check_eq("idle_EN", 32'(EN), 32'd0);
    check_eq("idle_Y", 32'(Y), 32'd0);
    check_eq("idle_starts", 32'(start_cnt), 32'd0);

    // Power on with exact release-to-enable latency
    btn[0] = 1'b0;
    tick(10);
    btn[0] = 1'b1;
    n = 0;
    while (!EN && n < 20) begin
      tick();
      n++;
    end
    check_eq("on_lat", 32'(n), 32'd7);
    check_eq("on_Y", 32'(Y), 32'd0);
    check_eq("on_sinal", 32'(sinal), 32'd0);

    alu_lat = 3;
    do_op(4'b0010, 100, 27, OP_ADD, 127, 1'b0);
    do_op(4'b0100, 5, 9, OP_SUB, 4, 1'b1);
    do_op(4'b1000, 127, 127, OP_MUL, 16129, 1'b0);

    // Short glitches must never produce an event
    base = start_cnt;
    repeat (5) begin
      btn[3] = 1'b0;
      tick(DB - 1);
      btn[3] = 1'b1;
      tick(4);
    end
    tick(20);
    check_eq("glitch_starts", 32'(start_cnt - base), 32'd0);
    check_eq("glitch_Y", 32'(Y), 32'd16129);
    check_eq("glitch_busy", 32'(busy), 32'd0);

    do_op(4'b0110, 20, 30, OP_ADD, 50, 1'b0);

    // Power off while waiting on the ALU; the late done must be ignored
    alu_lat = 9;
    A = 7'd10;
    B = 7'd20;
    tick(25);
    btn[0] = 1'b0;
    btn[1] = 1'b0;
    tick(10);
    btn[1] = 1'b1;
    n = 0;
    while (!alu_start && n < 20) begin
      tick();
      n++;
    end
    check_eq("off_launch_lat", 32'(n), 32'd7);
    btn[0] = 1'b1;
    tick(15);
    check_eq("off_EN", 32'(EN), 32'd0);
    check_eq("off_Y", 32'(Y), 32'd0);
    check_eq("off_sinal", 32'(sinal), 32'd0);
    check_eq("off_busy", 32'(busy), 32'd0);

    // Operand change while showing a result
    alu_lat = 3;
    btn[0]  = 1'b0;
    tick(10);
    btn[0] = 1'b1;
    tick(15);
    check_eq("reon_EN", 32'(EN), 32'd1);
    do_op(4'b0010, 3, 1, OP_ADD, 4, 1'b0);
    base = start_cnt;
    A = 7'd4;
    tick(30);
`ifdef CALC_AUTO_REFRESH_EN
    check_eq("refresh_Y", 32'(Y), 32'd5);
    check_eq("refresh_starts", 32'(start_cnt - base), 32'd1);
    exp_a = 4;
    exp_y = YW'(5);
`else
    check_eq("norefresh_Y", 32'(Y), 32'd4);
    check_eq("norefresh_starts", 32'(start_cnt - base), 32'd0);
    exp_a = 3;
    exp_y = YW'(4);
`endif

    // Random traffic against the transaction-level model
    exp_on     = 1'b1;
    exp_shown  = 1'b1;
    exp_neg    = 1'b0;
    exp_op     = OP_ADD;
    exp_b      = 1;
    exp_starts = start_cnt;
    for (int it = 0; it < 40; it++) begin
      int   act;
      int   idx;
      int   na;
      int   nb;
      logic [1:0] op;
      act     = int'($urandom_range(0, 9));
      alu_lat = int'($urandom_range(1, 5));
      if (act == 0) begin
        btn[0] = 1'b0;
        tick(int'($urandom_range(DB + 1, 12)));
        btn[0] = 1'b1;
        tick(30);
        exp_on    = !exp_on;
        exp_shown = 1'b0;
        exp_y     = '0;
        exp_neg   = 1'b0;
      end else if (act == 1) begin
        idx      = int'($urandom_range(0, 3));
        btn[idx] = 1'b0;
        tick(DB - 1);
        btn[idx] = 1'b1;
        tick(30);
      end else begin
        op = 2'($urandom_range(0, 2));
        na = int'($urandom_range(0, 127));
        nb = int'($urandom_range(0, 127));
        A  = W'(na);
        B  = W'(nb);
        tick(20);
`ifdef CALC_AUTO_REFRESH_EN
        if (exp_on && exp_shown && (na != exp_a || nb != exp_b)) begin
          exp_starts++;
          exp_a = na;
          exp_b = nb;
          alu_ref(exp_op, na, nb, exp_y, exp_neg);
        end
`endif
        btn[op + 1] = 1'b0;
        tick(int'($urandom_range(DB + 1, 12)));
        btn[op + 1] = 1'b1;
        tick(30);
        if (exp_on) begin
          exp_starts++;
          exp_shown = 1'b1;
          exp_op    = op;
          exp_a     = na;
          exp_b     = nb;
          alu_ref(op, na, nb, exp_y, exp_neg);
        end
      end
      check_eq("rnd_EN", 32'(EN), 32'(exp_on));
      check_eq("rnd_Y", 32'(Y), 32'(exp_y));
      check_eq("rnd_sinal", 32'(sinal), 32'(exp_neg));
      check_eq("rnd_busy", 32'(busy), 32'd0);
      check_eq("rnd_starts", 32'(start_cnt), 32'(exp_starts));
      if (exp_shown) begin
        check_eq("rnd_op", 32'(alu_op), 32'(exp_op));
        check_eq("rnd_a", 32'(alu_a), 32'(exp_a));
        check_eq("rnd_b", 32'(alu_b), 32'(exp_b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
